// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: one-outstanding imem fetcher feeding a DEPTH-entry {pc, instr} FIFO.
// Fetched word reaches valid_o one edge after rvalid; requests stop while count + outstanding reaches DEPTH.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pc_select_i,
    input  logic [31:0] pc_branch_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_src_o
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   req_pc_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];
    logic          accept, push, pop;
    logic          unused_branch_lsbs;

    assign unused_branch_lsbs = ^pc_branch_i[1:0];

    // Issue only from REQ, so count < DEPTH here already guarantees a free slot for the response.
    always_comb begin
        imem_req_o = (state_q == S_REQ) && (count_q < DEPTH_C) && !pc_select_i;
    end

    assign imem_addr_o = fpc_q;
    assign accept      = imem_req_o && imem_ready_i;
    assign push        = (state_q == S_WAIT) && imem_rvalid_i && !pc_select_i;
    assign pop         = valid_o && !stall_i && !pc_select_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // A response arriving in DISCARD always retires the stale request, even under a new redirect,
    // otherwise the FSM would wait for a response that never comes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:     if (accept) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid_i)    state_d = S_REQ;
                else if (pc_select_i) state_d = S_DISCARD;
            end
            S_DISCARD: if (imem_rvalid_i) state_d = S_REQ;
            default:   state_d = S_REQ;
        endcase
    end

    always_comb begin
        fpc_d = fpc_q;
        if (pc_select_i) begin
            fpc_d = {pc_branch_i[31:2], 2'b00};
        end else if (accept) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fpc_q    <= RESET_PC;
            req_pc_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q <= fpc_d;
            if (accept) begin
                req_pc_q <= fpc_q;
            end
            if (pc_select_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + (PW+1)'(1);
                    2'b01:   count_q <= count_q - (PW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= req_pc_q;
            ins_mem_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    assign valid_o       = (count_q != '0);
    assign instruction_o = valid_o ? ins_mem_q[rd_ptr_q] : NOP;
    assign pc_o          = valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign pc_src_o      = pc_o + 32'd4;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_prefetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        pc_select_i = 1'b0;
    logic [31:0] pc_branch_i = '0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        valid_o;
    logic [31:0] instruction_o, pc_o, pc_src_o;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .pc_select_i(pc_select_i), .pc_branch_i(pc_branch_i),
        .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .instruction_o(instruction_o), .pc_o(pc_o), .pc_src_o(pc_src_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

    // Reference model: the queue contents, the next fetch address, and whether a response is owed/stale.
    ent_t        mq[$];
    logic [31:0] m_fpc, m_req_pc;
    bit          m_out, m_drop;
    logic [31:0] dut_acc[$];
    logic [31:0] dut_pops[$];
    int          tests = 0;
    int          fails = 0;

    function automatic bit m_req();
        return !m_out && (mq.size() < DEPTH) && !pc_select_i;
    endfunction

    function automatic logic [129:0] exp_vec();
        logic [31:0] pc, ins;
        bit v;
        v   = (mq.size() != 0);
        pc  = v ? mq[0].pc : 32'h0;
        ins = v ? mq[0].ins : NOP;
        return {m_req(), m_fpc, v, pc, ins, pc + 32'd4};
    endfunction

    function automatic logic [129:0] dut_vec();
        return {imem_req_o, imem_addr_o, valid_o, pc_o, instruction_o, pc_src_o};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fpc = RESET_PC; m_req_pc = RESET_PC; m_out = 0; m_drop = 0;
    endtask

    task automatic drive(input bit sel, input logic [31:0] br, input bit st, input bit rdy, input bit rv);
        pc_select_i = sel; pc_branch_i = br; stall_i = st;
        imem_ready_i = rdy; imem_rvalid_i = rv; imem_rdata_i = $urandom;
    endtask

    task automatic tick();
        bit acc, rsp;
        if (imem_req_o && imem_ready_i) dut_acc.push_back(imem_addr_o);
        if (valid_o && !stall_i && !pc_select_i) dut_pops.push_back(pc_o);
        acc = m_req() && imem_ready_i;
        rsp = m_out && imem_rvalid_i;
        @(posedge clk_i);
        if (pc_select_i) begin
            mq.delete();
            m_fpc = {pc_branch_i[31:2], 2'b00};
            if (rsp) begin m_out = 0; m_drop = 0; end
            else if (m_out) m_drop = 1;
        end else begin
            if (mq.size() > 0 && !stall_i) void'(mq.pop_front());
            if (rsp) begin
                if (!m_drop) mq.push_back({m_req_pc, imem_rdata_i});
                m_out = 0; m_drop = 0;
            end
            if (acc) begin m_req_pc = m_fpc; m_fpc = m_fpc + 32'd4; m_out = 1; end
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        reset_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        model_reset();
        #1;
        tests++;
        if (dut_vec() !== {1'b1, RESET_PC, 1'b0, 32'h0, NOP, 32'h4}) begin
            fails++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), {1'b1, RESET_PC, 1'b0, 32'h0, NOP, 32'h4});
        end
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    task automatic test_streaming();
        do_reset();
        dut_pops.delete();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, m_out);
            #1; tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++; $display("FAIL stream cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            tick();
        end
        tests++;
        if (dut_pops.size() < 4 || dut_pops[0] !== 32'h0 || dut_pops[1] !== 32'h4
            || dut_pops[2] !== 32'h8 || dut_pops[3] !== 32'hC) begin
            fails++; $display("FAIL stream_order: got %0d pops starting %h want 0,4,8,C", dut_pops.size(),
                              dut_pops.size() > 0 ? dut_pops[0] : 32'hx);
        end
        for (int i = 1; i < dut_pops.size(); i++) begin
            tests++;
            if (dut_pops[i] !== dut_pops[i-1] + 32'd4) begin
                fails++; $display("FAIL stream_seq %0d: got %h want %h", i, dut_pops[i], dut_pops[i-1] + 32'd4);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        dut_acc.delete();
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 1, m_out);
            #1; tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++; $display("FAIL full_fill cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            tick();
        end
        drive(0, 0, 1, 1, 0);
        #1; tests++;
        if (dut_acc.size() != 4 || imem_req_o !== 1'b0) begin
            fails++; $display("FAIL full_accepts: got %0d accepts req=%b want 4 req=0", dut_acc.size(), imem_req_o);
        end
        dut_acc.delete(); dut_pops.delete();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, m_out);
            #1; tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++; $display("FAIL full_drain cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            tick();
        end
        tests++;
        if (dut_pops.size() < 4 || dut_pops[0] !== 32'h0 || dut_pops[1] !== 32'h4
            || dut_pops[2] !== 32'h8 || dut_pops[3] !== 32'hC) begin
            fails++; $display("FAIL full_pop_order: got %0d pops want 0,4,8,C", dut_pops.size());
        end
        tests++;
        if (dut_acc.size() == 0 || dut_acc[0] !== 32'h10) begin
            fails++; $display("FAIL full_resume: got %h want 00000010", dut_acc.size() ? dut_acc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 0;
        bit got = 0;
        logic [31:0] first_pc = 'x;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_out && m_req_pc == 32'h8) found = 1;
            else begin
                drive(0, 0, 0, 1, m_out);
                #1; tests++;
                if (dut_vec() !== exp_vec()) begin
                    fails++; $display("FAIL redir_approach cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
                end
                tick();
            end
        end
        tests++;
        if (!found) begin fails++; $display("FAIL redir_reach8: got timeout want request to 8 outstanding"); end
        dut_acc.delete();
        drive(1, 32'h100, 0, 1, 0);
        #1; tick();
        drive(0, 0, 0, 1, 1);
        #1; tests++;
        if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL redir_discard: got %h want %h", dut_vec(), exp_vec());
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, m_out);
            #1; tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++; $display("FAIL redir_refill cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (valid_o && !got) begin first_pc = pc_o; got = 1; end
            tick();
        end
        tests++;
        if (first_pc !== 32'h100 || dut_acc.size() == 0 || dut_acc[0] !== 32'h100) begin
            fails++; $display("FAIL redir_target: got pc %h first req %h want 00000100", first_pc,
                              dut_acc.size() ? dut_acc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_rvalid_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, m_out);
            #1; tick();
        end
        tests++;
        if (valid_o !== 1'b1) begin fails++; $display("FAIL rvp_prefill: got valid %b want 1", valid_o); end
        drive(1, 32'h40, 0, 1, 1);
        #1; tick();
        drive(0, 0, 1, 0, 0);
        #1; tests++;
        if ({valid_o, instruction_o, pc_o, imem_req_o, imem_addr_o} !== {1'b0, NOP, 32'h0, 1'b1, 32'h40}) begin
            fails++; $display("FAIL rvp_empty: got v=%b ins=%h pc=%h req=%b addr=%h want v=0 ins=00000013 pc=0 req=1 addr=40",
                              valid_o, instruction_o, pc_o, imem_req_o, imem_addr_o);
        end
        tick();
    endtask

    task automatic test_misaligned_wrap();
        do_reset();
        drive(1, 32'h203, 1, 0, 0);
        #1; tick();
        drive(0, 0, 1, 0, 0);
        #1; tests++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h200}) begin
            fails++; $display("FAIL misaligned: got req=%b addr=%h want 1 00000200", imem_req_o, imem_addr_o);
        end
        drive(1, 32'hFFFF_FFFC, 1, 0, 0);
        #1; tick();
        drive(0, 0, 1, 1, 0);
        #1; tick();
        drive(0, 0, 1, 1, 1);
        #1; tick();
        drive(0, 0, 1, 0, 0);
        #1; tests++;
        if ({imem_addr_o, pc_o, pc_src_o} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) begin
            fails++; $display("FAIL wrap: got addr=%h pc=%h pc_src=%h want 0 FFFFFFFC 0", imem_addr_o, pc_o, pc_src_o);
        end
        tick();
    endtask

    task automatic test_reset_midwait();
        do_reset();
        drive(0, 0, 1, 1, 0);
        #1; tick();
        drive(0, 0, 1, 0, 0);
        #1; tick();
        #2 reset_i = 1'b0;
        model_reset();
        #1; tests++;
        if (dut_vec() !== {1'b1, RESET_PC, 1'b0, 32'h0, NOP, 32'h4}) begin
            fails++; $display("FAIL midwait_reset: got %h want %h", dut_vec(), {1'b1, RESET_PC, 1'b0, 32'h0, NOP, 32'h4});
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        drive(0, 0, 1, 0, 1);
        #1; tick();
        drive(0, 0, 1, 0, 0);
        #1; tests++;
        if ({valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, RESET_PC}) begin
            fails++; $display("FAIL stray_rvalid: got v=%b req=%b addr=%h want 0 1 %h", valid_o, imem_req_o, imem_addr_o, RESET_PC);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(15) == 0), $urandom, ($urandom_range(9) < 3),
                  ($urandom_range(9) < 6), $urandom_range(1));
            #1; tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_redirect_wait();
        test_redirect_rvalid_pop();
        test_misaligned_wrap();
        test_reset_midwait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
